// File: rtl/phase1_dial_adc_sampler.sv
// phase1_dial_adc_sampler
// Purpose : serial-ADC read loop for the Phase-1 dial; averages 2^AVG_LOG2 12-bit
//           conversions and presents a stable dial value to the puzzle stage.
// Latency : one frame is 34*CLK_DIV cycles with cs_n low, then SAMPLE_GAP idle cycles;
//           a new value appears every 2^AVG_LOG2 frames, on the cycle cs_n returns high.
// Backpr. : none; dropping enable aborts the frame and discards the partial average.
// Ports   : in  clk, rst_n (async, active-low), enable, adc_miso
//           out adc_cs_n, adc_sclk, adc_mosi, adc_dial_val[11:0], sample_valid, busy
// Option  : define DIAL_HYST_EN to load a new average only when it differs from the
//           current dial value by at least HYST LSBs.
module phase1_dial_adc_sampler #(
    parameter int   CLK_DIV    = 25,
    parameter int   SAMPLE_GAP = 1000,
    parameter int   AVG_LOG2   = 2,
    parameter logic ADC_CH     = 1'b0,
    parameter int   HYST       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_mosi,
    output logic [11:0] adc_dial_val,
    output logic        sample_valid,
    output logic        busy
);
    // One shared down-timer covers both the SCLK half-period and the gap.
    localparam int CMAX = (CLK_DIV > SAMPLE_GAP) ? CLK_DIV : SAMPLE_GAP;
    localparam int CW   = $clog2(CMAX);
    localparam int AW   = 12 + AVG_LOG2;
    localparam int FW   = AVG_LOG2 + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(SAMPLE_GAP - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'((1 << AVG_LOG2) - 1);

    if (CLK_DIV < 2 || SAMPLE_GAP < 1 || AVG_LOG2 < 0 || AVG_LOG2 > 4 ||
        HYST < 0 || HYST > 4095) begin : g_bad_param
        $error("phase1_dial_adc_sampler: parameter out of legal range");
    end

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    slot_q, slot_d;
    logic [11:0]   shreg_q, shreg_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic [11:0]   val_q, val_d;
    logic          vld_q, vld_d;

    logic [AW-1:0] sum;
    logic [11:0]   avg;
    logic          take_avg;

    // Accumulator is 12+AVG_LOG2 wide, so 2^AVG_LOG2 full-scale frames cannot overflow.
    assign sum = acc_q + AW'(shreg_q);
    assign avg = 12'(sum >> AVG_LOG2);

`ifdef DIAL_HYST_EN
    logic [11:0] diff;
    assign diff     = (avg >= val_q) ? (avg - val_q) : (val_q - avg);
    assign take_avg = ({1'b0, diff} >= 13'(HYST));
`else
    assign take_avg = 1'b1;
`endif

    // Command word: start, single-ended, channel, MSB-first, then zeros.
    function automatic logic cmd_bit(input logic [3:0] slot);
        case (slot)
            4'd0, 4'd1, 4'd3: cmd_bit = 1'b1;
            4'd2:             cmd_bit = ADC_CH;
            default:          cmd_bit = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        frm_d   = frm_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        val_d   = val_q;
        vld_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (enable) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = cmd_bit(4'd0);
                end
            end
            SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    slot_d  = 4'd0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                // sclk_q doubles as the phase flag: 0 = low half, 1 = high half.
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // Capture on the edge where sclk rises; slots 0..3 carry no data.
                        if (slot_q >= 4'd4) begin
                            shreg_d = {shreg_q[10:0], adc_miso};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (slot_q == 4'd15) begin
                            state_d = HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            slot_d = slot_q + 4'd1;
                            mosi_d = cmd_bit(slot_q + 4'd1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    if (frm_q == FRM_LAST) begin
                        vld_d = 1'b1;
                        acc_d = '0;
                        frm_d = '0;
                        if (take_avg) begin
                            val_d = avg;
                        end
                    end else begin
                        acc_d = sum;
                        frm_d = frm_q + FW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                        mosi_d  = cmd_bit(4'd0);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase

        // Losing enable anywhere in the loop abandons the frame and the partial average.
        if (state_q != IDLE && !enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            slot_d  = 4'd0;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            acc_d   = '0;
            frm_d   = '0;
            val_d   = val_q;
            vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= 4'd0;
            shreg_q <= 12'd0;
            acc_q   <= '0;
            frm_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            val_q   <= 12'd0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            frm_q   <= frm_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            val_q   <= val_d;
            vld_q   <= vld_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_mosi     = mosi_q;
    assign adc_dial_val = val_q;
    assign sample_valid = vld_q;
    assign busy         = ~cs_n_q;

endmodule

// File: tb/tb_phase1_dial_adc_sampler.sv
// tb_phase1_dial_adc_sampler
// Purpose : drives phase1_dial_adc_sampler with a serial ADC model fed from a queue of
//           conversion results and compares the dial output against an averaging model.
// Ports   : none (top-level bench); clk period 10, DUT built with CLK_DIV=2, AVG_LOG2=2.
module tb_phase1_dial_adc_sampler;
    localparam int   CLK_DIV    = 2;
    localparam int   SAMPLE_GAP = 10;
    localparam int   AVG_LOG2   = 2;
    localparam logic ADC_CH     = 1'b0;
    localparam int   HYST       = 16;
    localparam int   NAVG       = 1 << AVG_LOG2;
    localparam int   BUDGET     = NAVG * (34 * CLK_DIV + SAMPLE_GAP) + 60;
`ifdef DIAL_HYST_EN
    localparam bit   HYST_ON    = 1'b1;
`else
    localparam bit   HYST_ON    = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        adc_miso = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_mosi;
    logic [11:0] adc_dial_val;
    logic        sample_valid;
    logic        busy;

    always #5 clk = ~clk;

    phase1_dial_adc_sampler #(
        .CLK_DIV   (CLK_DIV),
        .SAMPLE_GAP(SAMPLE_GAP),
        .AVG_LOG2  (AVG_LOG2),
        .ADC_CH    (ADC_CH),
        .HYST      (HYST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .adc_miso    (adc_miso),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .adc_mosi    (adc_mosi),
        .adc_dial_val(adc_dial_val),
        .sample_valid(sample_valid),
        .busy        (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected MOSI per slot: start, single-ended, channel, MSB-first, then zeros.
    function automatic logic cmd_exp(input int slot);
        logic [3:0] hdr;
        hdr = {1'b1, ADC_CH, 1'b1, 1'b1};
        return (slot < 4) ? hdr[slot] : 1'b0;
    endfunction

    // ADC model and bus monitor, all on the falling clk edge.
    int          q_data[$];
    logic [11:0] cur_data = 12'd0;
    int          rises = 0;
    int          falls = 0;
    int          low_len = 0;
    int          pulses = 0;
    bit          abort_expected = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (adc_cs_n) begin
            if (!prev_cs) begin
                if (abort_expected) abort_expected = 1'b0;
                else check("cs_low_len", low_len, 34 * CLK_DIV);
                check("sclk_idle", 32'(adc_sclk), 0);
                check("busy_cs_hi", 32'(busy), 0);
            end
            rises   = 0;
            low_len = 0;
        end else begin
            if (prev_cs) begin
                falls++;
                cur_data = (q_data.size() > 0) ? 12'(q_data.pop_front()) : 12'd0;
                check("busy_cs_lo", 32'(busy), 1);
            end
            low_len++;
            if (adc_sclk && !prev_sclk) begin
                if (rises < 16) check("mosi_slot", 32'(adc_mosi), 32'(cmd_exp(rises)));
                rises++;
            end
        end
        if (sample_valid) begin
            pulses++;
            check("vld_at_cs_rise", 32'({adc_cs_n, prev_cs}), 32'(2'b10));
        end
        adc_miso  = (rises >= 4 && rises <= 15) ? cur_data[15 - rises] : 1'b0;
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    int exp_val = 0;

    task automatic run_group(input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] d);
        int sum, avg, diff, p0, f0;
        sum  = int'(a) + int'(b) + int'(c) + int'(d);
        avg  = sum / NAVG;
        diff = (avg > exp_val) ? avg - exp_val : exp_val - avg;
        if (!HYST_ON || diff >= HYST) exp_val = avg;
        q_data.push_back(int'(a));
        q_data.push_back(int'(b));
        q_data.push_back(int'(c));
        q_data.push_back(int'(d));
        p0 = pulses;
        f0 = falls;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            #1;
            if (pulses != p0) break;
        end
        check("pulse_count", pulses - p0, 1);
        check("frames_per_avg", falls - f0, NAVG);
        check("dial_val", 32'(adc_dial_val), exp_val);
        @(negedge clk);
        #1;
        check("vld_one_cycle", 32'(sample_valid), 0);
    endtask

    initial begin
        int p0, f0;
        bit got;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", 32'(adc_cs_n), 1);
        check("rst_sclk", 32'(adc_sclk), 0);
        check("rst_mosi", 32'(adc_mosi), 0);
        check("rst_dial", 32'(adc_dial_val), 0);
        check("rst_vld", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("idle_cs_n", 32'(adc_cs_n), 1);

        // Single value, averaging, full scale
        enable = 1'b1;
        run_group(12'hABC, 12'hABC, 12'hABC, 12'hABC);
        run_group(12'd100, 12'd200, 12'd300, 12'd403);
        run_group(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        check("cursor", 32'(adc_dial_val[11:9]), 7);

        // Random conversions
        for (int g = 0; g < 6; g++) begin
            run_group(12'($urandom_range(4095)), 12'($urandom_range(4095)),
                      12'($urandom_range(4095)), 12'($urandom_range(4095)));
        end

        // Abort during slot 9 of the third frame of a group
        p0 = pulses;
        f0 = falls;
        for (int k = 0; k < 3; k++) q_data.push_back(int'($urandom_range(4095)));
        got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            #1;
            if (falls == f0 + 3 && rises == 9 && !adc_sclk) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_reached", 32'(got), 1);
        abort_expected = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        #1;
        check("abort_cs_n", 32'(adc_cs_n), 1);
        check("abort_sclk", 32'(adc_sclk), 0);
        check("abort_mosi", 32'(adc_mosi), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_vld", 32'(sample_valid), 0);
        check("abort_dial", 32'(adc_dial_val), exp_val);
        repeat (20) @(negedge clk);
        #1;
        check("abort_no_pulse", pulses - p0, 0);
        check("abort_idle", 32'(adc_cs_n), 1);
        q_data.delete();
        enable = 1'b1;
        run_group(12'h400, 12'h400, 12'h400, 12'h400);

        // Hysteresis boundaries around 0x800
        run_group(12'h800, 12'h800, 12'h800, 12'h800);
        run_group(12'h80A, 12'h80A, 12'h80A, 12'h80A);
        run_group(12'h7F0, 12'h7F0, 12'h7F0, 12'h7F0);
        run_group(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF);

        // Asynchronous reset in the middle of SHIFT
        got = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            #1;
            if (!adc_cs_n && rises == 5) begin
                got = 1'b1;
                break;
            end
        end
        check("shift_reached", 32'(got), 1);
        abort_expected = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_cs_n", 32'(adc_cs_n), 1);
        check("arst_sclk", 32'(adc_sclk), 0);
        check("arst_dial", 32'(adc_dial_val), 0);
        check("arst_vld", 32'(sample_valid), 0);
        check("arst_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        #1;
        check("arst_hold_cs_n", 32'(adc_cs_n), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
